// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : counter_scheduler
//  Description : Round-robin front end that time-shares one Top counter
//                between NUM_REQ requesters. Loads the winner's stop value
//                through the counter's active-low reset, waits for done under
//                a cycle watchdog and returns a tagged completion carrying the
//                measured run length.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int INPUT_WIDTH = 64,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT     = 1024,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_stop,
    output logic                           ctr_reset_l,
    output logic [INPUT_WIDTH-1:0]         ctr_stop,
    input  logic                           ctr_done,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [INPUT_WIDTH-1:0]         rsp_cycles,
    output logic                           rsp_timeout,
    output logic                           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_rr;
    logic [ID_W-1:0]        r_id;
    logic [INPUT_WIDTH-1:0] r_stop;
    logic [INPUT_WIDTH-1:0] r_elapsed;
    logic                   r_ctr_reset_l;
    logic                   r_rsp_valid;
    logic [INPUT_WIDTH-1:0] r_rsp_cycles;
    logic                   r_rsp_timeout;
    logic                   r_busy;

    logic [ID_W:0]          w_pos;
    logic                   w_found;
    logic [ID_W-1:0]        w_win;
    logic [ID_W-1:0]        w_rr_next;
    logic [INPUT_WIDTH-1:0] w_win_stop;
    logic                   w_grant;
    logic                   w_timeout_hit;

    // Circular priority search starting at the round-robin pointer; the
    // extra bit in w_pos lets the wrap be done by a single subtraction.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, r_rr} + (ID_W+1)'(i);
            if (w_pos >= (ID_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_pos[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_pos[ID_W-1:0];
            end
        end
    end

    // Grant is only offered from IDLE and never while reset is held.
    assign w_grant   = (r_state == S_IDLE) && !reset && w_found;
    assign w_rr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);

    // One-hot ready and the winner's stop value, selected by index.
    always_comb begin
        req_ready  = '0;
        w_win_stop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                req_ready[i] = w_grant;
                w_win_stop   = req_stop[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // Watchdog compares against the cleared-in-LOAD run counter; a zero
    // TIMEOUT removes the abort path entirely.
    assign w_timeout_hit = (TIMEOUT != 0) && (r_elapsed == INPUT_WIDTH'(TIMEOUT));

    // Scheduler FSM with all counter-side and response outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_id          <= '0;
            r_stop        <= '0;
            r_elapsed     <= '0;
            r_ctr_reset_l <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_cycles  <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_stop  <= w_win_stop;
                        r_id    <= w_win;
                        r_rr    <= w_rr_next;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Counter captures ctr_stop during this cycle, then runs.
                    r_elapsed     <= '0;
                    r_ctr_reset_l <= 1'b1;
                    r_state       <= S_RUN;
                end
                S_RUN: begin
                    if (ctr_done) begin
                        r_rsp_cycles  <= r_elapsed;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_ctr_reset_l <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_rsp_cycles  <= INPUT_WIDTH'(TIMEOUT);
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_ctr_reset_l <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_elapsed != '1) begin
                        r_elapsed <= r_elapsed + INPUT_WIDTH'(1);
                    end
                end
                S_RESP: begin
                    // Counter stays parked in reset until the response drains.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctr_reset_l = r_ctr_reset_l;
    assign ctr_stop    = r_stop;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_id;
    assign rsp_cycles  = r_rsp_cycles;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_scheduler
//  Description : Directed self-checking bench for counter_scheduler with a
//                small behavioural model of the attached Top counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_scheduler;

    localparam int IW = 16;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*IW-1:0]  req_stop;
    logic              ctr_reset_l;
    logic [IW-1:0]     ctr_stop;
    logic              ctr_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [IW-1:0]     rsp_cycles;
    logic              rsp_timeout;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    counter_scheduler #(
        .INPUT_WIDTH (IW),
        .NUM_REQ     (NR),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_stop    (req_stop),
        .ctr_reset_l (ctr_reset_l),
        .ctr_stop    (ctr_stop),
        .ctr_done    (ctr_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_cycles  (rsp_cycles),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Cycle index, stable between rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Top counter model: reset_l low clears count and captures stop;
    // done when the running count reaches stop.
    logic [IW-1:0] m_cnt  = '0;
    logic [IW-1:0] m_stop = '0;
    always @(posedge clk) begin
        if (ctr_reset_l !== 1'b1) begin
            m_cnt  <= '0;
            m_stop <= ctr_stop;
        end else begin
            m_cnt <= m_cnt + 1'b1;
        end
    end
    assign ctr_done = (ctr_reset_l === 1'b1) && (m_cnt == m_stop);

    // Waits (bounded) for rsp_valid at negedges; lat is cycles since t0 or -1.
    task automatic wait_rsp(input int t0, output int lat);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = (rsp_valid === 1'b1) ? (cyc - t0) : -1;
    endtask

    // Waits (bounded) for any req_ready; ok is 0 if none appeared.
    task automatic wait_grant(output bit ok);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (req_ready != '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'b1111; req_stop = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ctr_reset_l !== 1'b0) begin failures++; $display("FAIL reset_ctr_reset_l: got %b want 0", ctr_reset_l); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_cycles !== 16'd0) begin failures++; $display("FAIL reset_rsp_cycles: got %0d want 0", rsp_cycles); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL reset_rsp_timeout: got %b want 0", rsp_timeout); end
        checks++; if (ctr_stop !== 16'd0) begin failures++; $display("FAIL reset_ctr_stop: got %0d want 0", ctr_stop); end
        reset = 1'b0; req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single_run();
        int t, lat;
        req_stop[0*IW +: IW] = 16'd5;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        checks++; if (ctr_reset_l !== 1'b0) begin failures++; $display("FAIL single_load_reset_l: got %b want 0", ctr_reset_l); end
        checks++; if (ctr_stop !== 16'd5) begin failures++; $display("FAIL single_ctr_stop: got %0d want 5", ctr_stop); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_in_load: got %b want 0000", req_ready); end
        @(negedge clk);
        checks++; if (ctr_reset_l !== 1'b1) begin failures++; $display("FAIL single_run_reset_l: got %b want 1", ctr_reset_l); end
        wait_rsp(t, lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL single_latency: got %0d want 8", lat); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_cycles !== 16'd5) begin failures++; $display("FAIL single_cycles: got %0d want 5", rsp_cycles); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b want 0", rsp_timeout); end
        checks++; if (ctr_reset_l !== 1'b0) begin failures++; $display("FAIL single_resp_reset_l: got %b want 0", ctr_reset_l); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_back_idle: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_zero_stop();
        int t, lat;
        req_stop[2*IW +: IW] = 16'd0;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL zero_grant: got %b want 0100", req_ready); end
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL zero_latency: got %0d want 3", lat); end
        checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL zero_id: got %0d want 2", rsp_id); end
        checks++; if (rsp_cycles !== 16'd0) begin failures++; $display("FAIL zero_cycles: got %0d want 0", rsp_cycles); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int stops [4];
        int t, t_prev, lat, exp_id, prev_id;
        bit ok;
        logic [NR-1:0] exp_rdy;
        stops = '{3, 1, 4, 2};
        do_reset();
        for (int i = 0; i < NR; i++) req_stop[i*IW +: IW] = IW'(stops[i]);
        req_valid = 4'b1111;
        t_prev = 0; prev_id = 0;
        for (int g = 0; g < 5; g++) begin
            exp_id  = g % NR;
            exp_rdy = NR'(1) << exp_id;
            wait_grant(ok);
            checks++; if (!ok || req_ready !== exp_rdy) begin failures++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, exp_rdy); end
            t = cyc;
            if (g > 0) begin
                checks++; if (t - t_prev !== stops[prev_id] + 4) begin failures++; $display("FAIL fair_spacing%0d: got %0d want %0d", g, t - t_prev, stops[prev_id] + 4); end
            end
            @(negedge clk);
            wait_rsp(t, lat);
            checks++; if (lat !== stops[exp_id] + 3) begin failures++; $display("FAIL fair_latency%0d: got %0d want %0d", g, lat, stops[exp_id] + 3); end
            checks++; if (rsp_id !== 2'(exp_id)) begin failures++; $display("FAIL fair_id%0d: got %0d want %0d", g, rsp_id, exp_id); end
            checks++; if (rsp_cycles !== IW'(stops[exp_id])) begin failures++; $display("FAIL fair_cycles%0d: got %0d want %0d", g, rsp_cycles, stops[exp_id]); end
            if (g == 4) req_valid = '0;
            t_prev = t; prev_id = exp_id;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int t, lat;
        req_stop[1*IW +: IW] = 16'd100;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL to_grant: got %b want 0010", req_ready); end
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t, lat);
        checks++; if (lat !== 19) begin failures++; $display("FAIL to_latency: got %0d want 19", lat); end
        checks++; if (rsp_timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b want 1", rsp_timeout); end
        checks++; if (rsp_cycles !== 16'd16) begin failures++; $display("FAIL to_cycles: got %0d want 16", rsp_cycles); end
        checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL to_id: got %0d want 1", rsp_id); end
        @(negedge clk);
        req_stop[1*IW +: IW] = 16'd16;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL edge_grant: got %b want 0010", req_ready); end
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t, lat);
        checks++; if (lat !== 19) begin failures++; $display("FAIL edge_latency: got %0d want 19", lat); end
        checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL edge_flag: got %b want 0", rsp_timeout); end
        checks++; if (rsp_cycles !== 16'd16) begin failures++; $display("FAIL edge_cycles: got %0d want 16", rsp_cycles); end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        int t, lat;
        rsp_ready = 1'b0;
        req_stop[3*IW +: IW] = 16'd2;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
        t = cyc;
        @(negedge clk);
        req_stop[0*IW +: IW] = 16'd1;
        req_valid = 4'b0001;
        wait_rsp(t, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL bp_latency: got %0d want 5", lat); end
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_cycles !== 16'd2 || rsp_timeout !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d: got v=%b id=%0d cyc=%0d to=%b want 1 3 2 0", i, rsp_valid, rsp_id, rsp_cycles, rsp_timeout);
            end
            checks++; if (ctr_reset_l !== 1'b0 || req_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_parked%0d: got reset_l=%b ready=%b want 0 0000", i, ctr_reset_l, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t, lat);
        checks++; if (lat !== 4 || rsp_id !== 2'd0 || rsp_cycles !== 16'd1) begin
            failures++; $display("FAIL bp_next_rsp: got lat=%0d id=%0d cyc=%0d want 4 0 1", lat, rsp_id, rsp_cycles);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int t, lat;
        req_stop[2*IW +: IW] = 16'd10;
        req_stop[1*IW +: IW] = 16'd2;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        checks++; if (ctr_reset_l !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_running: got reset_l=%b busy=%b want 1 1", ctr_reset_l, busy); end
        reset = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ctr_reset_l !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL mid_state: got busy=%b reset_l=%b valid=%b want 0 0 0", busy, ctr_reset_l, rsp_valid);
        end
        checks++; if (rsp_id !== 2'd0 || rsp_cycles !== 16'd0 || rsp_timeout !== 1'b0 || ctr_stop !== 16'd0) begin
            failures++; $display("FAIL mid_payload: got id=%0d cyc=%0d to=%b stop=%0d want 0 0 0 0", rsp_id, rsp_cycles, rsp_timeout, ctr_stop);
        end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_rr_restart: got %b want 0010", req_ready); end
        t = cyc;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(t, lat);
        checks++; if (lat !== 5 || rsp_id !== 2'd1 || rsp_cycles !== 16'd2) begin
            failures++; $display("FAIL mid_after_rsp: got lat=%0d id=%0d cyc=%0d want 5 1 2", lat, rsp_id, rsp_cycles);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_stop = '0; rsp_ready = 1'b1;
        test_reset();
        test_single_run();
        test_zero_stop();
        test_fairness();
        test_timeout();
        test_back_pressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/counter_scheduler.md
# counter_scheduler

Shares one `Top` counter instance between `NUM_REQ` requesters. Round-robin arbitrates run requests, loads the winner's stop value into the counter through its active-low reset, and waits for `done` under a cycle watchdog. It then returns a tagged completion with the measured run length. It sits directly in front of `Top` and owns its `reset_l` and `stop` inputs.

## Interface
- `INPUT_WIDTH`, default 64: counter/stop width; must equal the attached `Top` instance's `INPUT_WIDTH`.
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `TIMEOUT`, default 1024: maximum RUN cycles before abort; 0 disables the watchdog.
- `ID_W`, default `$clog2(NUM_REQ)`: requester id width; derived, not overridden.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester run request.
- `req_ready` output NUM_REQ: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `req_stop` input NUM_REQ*INPUT_WIDTH: packed stop values; requester i uses bits `[i*INPUT_WIDTH +: INPUT_WIDTH]`.
- `ctr_reset_l` output 1: drives `Top.reset_l`.
- `ctr_stop` output INPUT_WIDTH: drives `Top.stop`.
- `ctr_done` input 1: from `Top.done`.
- `rsp_valid` output 1: completion valid.
- `rsp_ready` input 1: completion accept.
- `rsp_id` output ID_W: index of the requester served.
- `rsp_cycles` output INPUT_WIDTH: RUN cycles elapsed before `ctr_done` or timeout.
- `rsp_timeout` output 1: run aborted by the watchdog.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, LOAD, RUN, RESP.
- **IDLE**
  - `ctr_reset_l`=0.
  - If any `req_valid` is set, `req_ready` is driven combinationally one-hot to the round-robin winner.
  - The winner's stop value is latched into `stop_q` and its index into `id_q`, then the FSM moves to LOAD.
  - With no request, the FSM stays in IDLE.
- **LOAD** (exactly 1 cycle)
  - `ctr_reset_l`=0, so `Top` captures `ctr_stop` and clears its counter.
  - `elapsed` is cleared; the FSM moves to RUN.
- **RUN**
  - `ctr_reset_l`=1.
  - If `ctr_done`=1: latch `rsp_cycles`=`elapsed`, `rsp_timeout`=0, go to RESP.
  - Else if `TIMEOUT`≠0 and `elapsed`==`TIMEOUT`: latch `rsp_cycles`=`TIMEOUT`, `rsp_timeout`=1, go to RESP.
  - Otherwise increment `elapsed` and stay in RUN.
  - When `ctr_done` and the timeout hit in the same cycle, `ctr_done` wins.
- **RESP**
  - `ctr_reset_l`=0, which parks the counter.
  - `rsp_valid`=1, with `rsp_id`/`rsp_cycles`/`rsp_timeout` held stable.
  - When `rsp_ready`=1, move to IDLE.
- `ctr_stop` is always driven from `stop_q`.
- `req_ready` is 0 in every state except IDLE.
- **Round-robin arbitration**
  - The pointer `rr_q` holds the highest-priority index.
  - Priority is searched circularly from `rr_q`.
  - On each grant, `rr_q` ← winner+1 mod `NUM_REQ`.
- **Arithmetic:** `elapsed` is INPUT_WIDTH wide and saturates at all-ones rather than wrapping; this only matters when `TIMEOUT`=0.
- **Requester rules:** a requester must hold `req_valid` and `req_stop` stable until it is granted. Withdrawal before grant is permitted, and the arbiter then considers only the current `req_valid`.
- **Reset values** (take effect on the next edge whenever `reset`=1, including mid-RUN or mid-RESP):
  - state=IDLE, `rr_q`=0, `stop_q`=0, `id_q`=0, `elapsed`=0.
  - `ctr_reset_l`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_cycles`=0, `rsp_timeout`=0, `busy`=0.
  - `req_ready`=0 while `reset` is asserted.
  - A run in progress is discarded without a response.

## Timing
- **Run sequence** (grant in cycle t, stop=S):
  - LOAD at t+1.
  - RUN from t+2; the counter value in RUN cycle k is k.
  - `ctr_done` is sampled at t+2+S.
  - `rsp_valid` rises at t+3+S.
- **Response and back-to-back issue:**
  - With `rsp_ready` held high, RESP lasts 1 cycle.
  - The earliest next grant is at t+4+S.
  - Per run: S+4 cycles grant-to-next-grant.
- **stop=0:** `ctr_done` is high in the first RUN cycle; `rsp_cycles`=0.
- **Back-pressure:** RESP holds indefinitely and all outputs stay stable until `rsp_ready`. The counter stays parked in reset meanwhile.
- **Grant:** `req_ready` is combinational from `req_valid` and `rr_q` in IDLE only. All other outputs are registered.

## Test plan
- **Single run:** reset 2 cycles; `req_valid[0]`=1, stop=5 → grant at t, `ctr_reset_l` 0 through t+1 and 1 from t+2. `rsp_valid` at t+8 with `rsp_id`=0, `rsp_cycles`=5, `rsp_timeout`=0.
- **Zero stop:** requester 2, stop=0 → `rsp_cycles`=0, `rsp_valid` at t+3.
- **Fairness:** all 4 requesters hold valid with stops 3,1,4,2 → grant order 0,1,2,3,0… Each response carries the matching id and cycles; no requester is granted twice before all others are served.
- **Timeout:** `TIMEOUT`=16, stop=100 → `rsp_timeout`=1, `rsp_cycles`=16, `rsp_valid` at t+19. A second run with stop=16 completes normally with cycles=16 (done beats the timeout).
- **Back-pressure:** `rsp_ready`=0 for 10 cycles → `rsp_valid` and payload held stable, `ctr_reset_l`=0, no new `req_ready`. The cycle after `rsp_ready`=1: IDLE, then grant.
- **Reset mid-run:** assert `reset` in RUN at k=3 of stop=10 → next cycle IDLE with all outputs at reset values, no response emitted. A subsequent request from requester 1 is granted first because `rr_q`=0 and requester 0 is idle.
